// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic.
//   state_t    : hazard FSM encodings (RUN, LU_STALL, MEM_WAIT, REDIRECT)
//   FWD_*      : ALU operand-select codes driven on FWD_A / FWD_B
//   REG_ZERO   : index of $zero, which is never a real dependency
package mips_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;  // register-file read data
    localparam logic [1:0] FWD_WB  = 2'b01;  // write-back data
    localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_unit.sv
// Combinational bypass-select compare for the two EX-stage ALU operands.
// Inputs : EX-stage source registers, MEM- and WB-stage write enables and
//          destinations.
// Outputs: FWD_A / FWD_B operand selects (FWD_RF / FWD_WB / FWD_MEM).
module fwd_unit
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] IDEX_Rs,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic             EXMEM_RegWrite,
    input  logic [REG_W-1:0] EXMEM_WRITE_REG,
    input  logic             MEMWB_RegWrite,
    input  logic [REG_W-1:0] MEMWB_WRITE_REG,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B
);

    logic mem_live, wb_live;

    // A write to $zero is discarded by the register file, so never bypass it.
    assign mem_live = EXMEM_RegWrite && (EXMEM_WRITE_REG != REG_W'(REG_ZERO));
    assign wb_live  = MEMWB_RegWrite && (MEMWB_WRITE_REG != REG_W'(REG_ZERO));

    // The MEM-stage producer is younger, so its value wins over WB.
    always_comb begin
        FWD_A = FWD_RF;
        if (mem_live && (EXMEM_WRITE_REG == IDEX_Rs))     FWD_A = FWD_MEM;
        else if (wb_live && (MEMWB_WRITE_REG == IDEX_Rs)) FWD_A = FWD_WB;
    end

    always_comb begin
        FWD_B = FWD_RF;
        if (mem_live && (EXMEM_WRITE_REG == IDEX_Rt))     FWD_B = FWD_MEM;
        else if (wb_live && (MEMWB_WRITE_REG == IDEX_Rt)) FWD_B = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Inputs : pipeline register fields (IF/ID, ID/EX, EX/MEM, MEM/WB), PC_SRC
//          (taken branch in MEM), MEM_READY (data memory done).
// Outputs: PC_WRITE / IFID_WRITE enables, IFID_FLUSH / IDEX_BUBBLE /
//          EXMEM_FLUSH squashes, FWD_A / FWD_B bypass selects, STATE, and
//          saturating STALL_CNT / FLUSH_CNT performance counters.
// Event priority per cycle: memory freeze > branch > jump > load-use.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic [REG_W-1:0] IDEX_Rs,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_Jump,
    input  logic             EXMEM_RegWrite,
    input  logic [REG_W-1:0] EXMEM_WRITE_REG,
    input  logic             MEMWB_RegWrite,
    input  logic [REG_W-1:0] MEMWB_WRITE_REG,
    input  logic             PC_SRC,
    input  logic             MEM_READY,
    output logic             PC_WRITE,
    output logic             IFID_WRITE,
    output logic             IFID_FLUSH,
    output logic             IDEX_BUBBLE,
    output logic             EXMEM_FLUSH,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]       fwd_a, fwd_b;
    logic             lu_hit, lu_armed, stall_inc, flush_inc;

    fwd_unit #(.REG_W(REG_W)) u_fwd (
        .IDEX_Rs         (IDEX_Rs),
        .IDEX_Rt         (IDEX_Rt),
        .EXMEM_RegWrite  (EXMEM_RegWrite),
        .EXMEM_WRITE_REG (EXMEM_WRITE_REG),
        .MEMWB_RegWrite  (MEMWB_RegWrite),
        .MEMWB_WRITE_REG (MEMWB_WRITE_REG),
        .FWD_A           (fwd_a),
        .FWD_B           (fwd_b)
    );

    // Bypass selects fall back to the register file while in reset.
    assign FWD_A = RST_N ? fwd_a : FWD_RF;
    assign FWD_B = RST_N ? fwd_b : FWD_RF;

    assign lu_hit = IDEX_MemRead && (IDEX_Rt != REG_W'(REG_ZERO)) &&
                    ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

    // After a stall the dependent instruction is still in ID but the load has
    // moved on; after a redirect ID holds a NOP. Either way skip the check.
    assign lu_armed = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

    always_comb begin
        PC_WRITE    = 1'b1;
        IFID_WRITE  = 1'b1;
        IFID_FLUSH  = 1'b0;
        IDEX_BUBBLE = 1'b0;
        EXMEM_FLUSH = 1'b0;
        state_d     = ST_RUN;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!RST_N) begin
            // hold RUN-style outputs while reset is asserted
        end else if (!MEM_READY) begin
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
            state_d    = ST_MEM_WAIT;
            stall_inc  = 1'b1;
        end else if (PC_SRC) begin
            IFID_FLUSH  = 1'b1;
            IDEX_BUBBLE = 1'b1;
            EXMEM_FLUSH = 1'b1;
            state_d     = ST_REDIRECT;
            flush_inc   = 1'b1;
        end else if (IDEX_Jump) begin
            IFID_FLUSH  = 1'b1;
            IDEX_BUBBLE = 1'b1;
            state_d     = ST_REDIRECT;
            flush_inc   = 1'b1;
        end else if (lu_hit && lu_armed) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_BUBBLE = 1'b1;
            state_d     = ST_LU_STALL;
            stall_inc   = 1'b1;
        end
    end

    // Counters saturate at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign STATE     = state_q;
    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. A second instance with a
// 2-bit counter width shares all stimulus to exercise counter saturation.
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rs, IDEX_Rt, EXMEM_WRITE_REG, MEMWB_WRITE_REG;
    logic        IFID_UsesRt, IDEX_MemRead, IDEX_Jump, EXMEM_RegWrite, MEMWB_RegWrite;
    logic        PC_SRC, MEM_READY;
    logic        PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_BUBBLE, EXMEM_FLUSH;
    logic [1:0]  FWD_A, FWD_B, STATE;
    logic [15:0] STALL_CNT, FLUSH_CNT;
    logic        s_pcw, s_ifw, s_iff, s_idb, s_exf;
    logic [1:0]  s_fa, s_fb, s_st;
    logic [1:0]  s_stall, s_flush;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Jump(IDEX_Jump), .EXMEM_RegWrite(EXMEM_RegWrite),
        .EXMEM_WRITE_REG(EXMEM_WRITE_REG), .MEMWB_RegWrite(MEMWB_RegWrite),
        .MEMWB_WRITE_REG(MEMWB_WRITE_REG), .PC_SRC(PC_SRC), .MEM_READY(MEM_READY),
        .PC_WRITE(PC_WRITE), .IFID_WRITE(IFID_WRITE), .IFID_FLUSH(IFID_FLUSH),
        .IDEX_BUBBLE(IDEX_BUBBLE), .EXMEM_FLUSH(EXMEM_FLUSH),
        .FWD_A(FWD_A), .FWD_B(FWD_B), .STATE(STATE),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    hazard_ctrl #(.CNT_W(2), .REG_W(5)) dut_sat (
        .CLK(CLK), .RST_N(RST_N),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Jump(IDEX_Jump), .EXMEM_RegWrite(EXMEM_RegWrite),
        .EXMEM_WRITE_REG(EXMEM_WRITE_REG), .MEMWB_RegWrite(MEMWB_RegWrite),
        .MEMWB_WRITE_REG(MEMWB_WRITE_REG), .PC_SRC(PC_SRC), .MEM_READY(MEM_READY),
        .PC_WRITE(s_pcw), .IFID_WRITE(s_ifw), .IFID_FLUSH(s_iff),
        .IDEX_BUBBLE(s_idb), .EXMEM_FLUSH(s_exf),
        .FWD_A(s_fa), .FWD_B(s_fb), .STATE(s_st),
        .STALL_CNT(s_stall), .FLUSH_CNT(s_flush)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        IFID_Rs = 0; IFID_Rt = 0; IFID_UsesRt = 0;
        IDEX_Rs = 0; IDEX_Rt = 0; IDEX_MemRead = 0; IDEX_Jump = 0;
        EXMEM_RegWrite = 0; EXMEM_WRITE_REG = 0;
        MEMWB_RegWrite = 0; MEMWB_WRITE_REG = 0;
        PC_SRC = 0; MEM_READY = 1;
        #1;
    endtask

    // lw $2 in EX, add $3,$2,$4 in ID
    task automatic lu_hazard();
        idle();
        IDEX_MemRead = 1; IDEX_Rt = 5'd2; IDEX_Rs = 5'd1;
        IFID_Rs = 5'd2; IFID_Rt = 5'd4; IFID_UsesRt = 1;
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 0;
        lu_hazard();
        EXMEM_RegWrite = 1; EXMEM_WRITE_REG = 5'd1;  // would forward to Rs=1
        #1;
        chk("rst_state", STATE, 0);
        chk("rst_stall_cnt", STALL_CNT, 0);
        chk("rst_flush_cnt", FLUSH_CNT, 0);
        chk("rst_pc_write", PC_WRITE, 1);
        chk("rst_ifid_write", IFID_WRITE, 1);
        chk("rst_bubble", IDEX_BUBBLE, 0);
        chk("rst_fwd_a", FWD_A, 0);
        step();
        chk("rst_hold_state", STATE, 0);
        @(negedge CLK);
        RST_N = 1;

        // load-use stall
        lu_hazard();
        chk("lu_pc_write", PC_WRITE, 0);
        chk("lu_ifid_write", IFID_WRITE, 0);
        chk("lu_bubble", IDEX_BUBBLE, 1);
        chk("lu_ifid_flush", IFID_FLUSH, 0);
        step();
        chk("lu_state", STATE, 1);
        chk("lu_stall_cnt", STALL_CNT, 1);
        // bubble in EX, lw in MEM, add still in ID with inputs still matching
        idle();
        EXMEM_RegWrite = 1; EXMEM_WRITE_REG = 5'd2;
        IFID_Rs = 5'd2; IFID_Rt = 5'd4; IFID_UsesRt = 1;
        #1;
        chk("lus_pc_write", PC_WRITE, 1);
        chk("lus_bubble", IDEX_BUBBLE, 0);
        step();
        chk("lus_exit_state", STATE, 0);
        // add in EX, lw in WB
        idle();
        IDEX_Rs = 5'd2; IDEX_Rt = 5'd4;
        MEMWB_RegWrite = 1; MEMWB_WRITE_REG = 5'd2;
        #1;
        chk("lu_fwd_a_wb", FWD_A, 1);
        chk("lu_fwd_b_rf", FWD_B, 0);
        chk("lu_stall_cnt_hold", STALL_CNT, 1);

        // add $2 then sub $5,$2,$2
        idle();
        IDEX_Rs = 5'd2; IDEX_Rt = 5'd2;
        EXMEM_RegWrite = 1; EXMEM_WRITE_REG = 5'd2;
        MEMWB_RegWrite = 1; MEMWB_WRITE_REG = 5'd2;
        #1;
        chk("fwd_a_mem", FWD_A, 2);
        chk("fwd_b_mem", FWD_B, 2);
        chk("fwd_no_stall", PC_WRITE, 1);
        EXMEM_RegWrite = 0;
        #1;
        chk("fwd_a_wb_only", FWD_A, 1);
        IDEX_Rs = 5'd0; IDEX_Rt = 5'd0;
        EXMEM_RegWrite = 1; EXMEM_WRITE_REG = 5'd0; MEMWB_WRITE_REG = 5'd0;
        #1;
        chk("fwd_a_zero", FWD_A, 0);
        chk("fwd_b_zero", FWD_B, 0);
        IDEX_Rs = 5'd7; IDEX_Rt = 5'd3;
        EXMEM_WRITE_REG = 5'd3; MEMWB_WRITE_REG = 5'd7; MEMWB_RegWrite = 0;
        #1;
        chk("fwd_a_wb_disabled", FWD_A, 0);
        chk("fwd_b_mem_rt", FWD_B, 2);
        step();

        // branch and jump in the same cycle, with a load-use also present
        lu_hazard();
        PC_SRC = 1; IDEX_Jump = 1;
        #1;
        chk("br_ifid_flush", IFID_FLUSH, 1);
        chk("br_bubble", IDEX_BUBBLE, 1);
        chk("br_exmem_flush", EXMEM_FLUSH, 1);
        chk("br_pc_write", PC_WRITE, 1);
        step();
        chk("br_state", STATE, 3);
        chk("br_flush_cnt", FLUSH_CNT, 1);
        chk("br_stall_cnt", STALL_CNT, 1);
        lu_hazard();  // suppressed in REDIRECT
        chk("redir_pc_write", PC_WRITE, 1);
        chk("redir_bubble", IDEX_BUBBLE, 0);
        step();
        chk("redir_exit", STATE, 0);
        idle();
        IDEX_Jump = 1;
        #1;
        chk("jmp_ifid_flush", IFID_FLUSH, 1);
        chk("jmp_bubble", IDEX_BUBBLE, 1);
        chk("jmp_exmem_flush", EXMEM_FLUSH, 0);
        step();
        chk("jmp_state", STATE, 3);
        chk("jmp_flush_cnt", FLUSH_CNT, 2);
        idle();
        step();
        chk("jmp_exit", STATE, 0);

        // memory freeze for 3 cycles over a load-use hazard
        for (int i = 0; i < 3; i++) begin
            lu_hazard();
            MEM_READY = 0;
            #1;
            chk("frz_pc_write", PC_WRITE, 0);
            chk("frz_ifid_write", IFID_WRITE, 0);
            chk("frz_bubble", IDEX_BUBBLE, 0);
            step();
            chk("frz_state", STATE, 2);
        end
        chk("frz_stall_cnt", STALL_CNT, 4);
        lu_hazard();
        chk("frz_lu_bubble", IDEX_BUBBLE, 1);
        chk("frz_lu_pc_write", PC_WRITE, 0);
        step();
        chk("frz_lu_state", STATE, 1);
        chk("frz_lu_stall_cnt", STALL_CNT, 5);
        lu_hazard();
        chk("frz_lus_suppressed", IDEX_BUBBLE, 0);
        step();
        chk("frz_lus_exit", STATE, 0);

        // 2-bit counters saturate
        chk("sat_stall_cnt", s_stall, 3);
        chk("sat_flush_cnt", s_flush, 2);
        chk("sat_state", s_st, 0);

        // async reset in the middle of a load-use stall
        lu_hazard();
        step();
        chk("mid_state_pre", STATE, 1);
        #2;
        RST_N = 0;
        #1;
        chk("mid_rst_state", STATE, 0);
        chk("mid_rst_stall", STALL_CNT, 0);
        chk("mid_rst_flush", FLUSH_CNT, 0);
        chk("mid_rst_pc_write", PC_WRITE, 1);
        chk("mid_rst_sat_stall", s_stall, 0);
        @(negedge CLK);
        RST_N = 1;
        idle();
        step();
        chk("post_rst_state", STATE, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives register-file bypass selects, load-use stalls, branch/jump flushes and data-memory wait freezes.
- Keeps saturating performance counters.
- Sits beside the datapath. Its control outputs gate the IF/ID, ID/EX and EX/MEM pipeline-register updates at the next CLK edge.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters (saturating).
- REG_W, 5, register-specifier width.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IFID_Rs, IFID_Rt  in  REG_W each  source registers of the instruction in ID.
- IFID_UsesRt  in  1  ID instruction reads Rt (R-type, store, beq).
- IDEX_Rs, IDEX_Rt  in  REG_W each  source registers of the instruction in EX.
- IDEX_MemRead  in  1  EX instruction is a load.
- IDEX_Jump  in  1  jump resolved in EX.
- EXMEM_RegWrite  in  1  MEM-stage writes the register file.
- EXMEM_WRITE_REG  in  REG_W  MEM-stage destination.
- MEMWB_RegWrite  in  1  WB-stage writes the register file.
- MEMWB_WRITE_REG  in  REG_W  WB-stage destination.
- PC_SRC  in  1  taken branch resolved in MEM.
- MEM_READY  in  1  data memory done; 0 freezes the pipeline.
- PC_WRITE  out  1  PC register enable.
- IFID_WRITE  out  1  IF/ID register enable.
- IFID_FLUSH  out  1  load NOP into IF/ID.
- IDEX_BUBBLE  out  1  zero ID/EX control bits.
- EXMEM_FLUSH  out  1  zero EX/MEM control bits.
- FWD_A, FWD_B  out  2 each  ALU operand select: 00 register file, 01 WB data, 10 EX/MEM ALU result.
- STATE  out  2  FSM state.
- STALL_CNT  out  CNT_W  stall cycles seen.
- FLUSH_CNT  out  CNT_W  redirect events seen.

Behaviour:
- Reset (RST_N=0, asynchronous): STATE=RUN, counters=0.
- Combinational outputs during reset: PC_WRITE=1, IFID_WRITE=1, all flush/bubble=0, FWD=00.
- Forwarding (purely combinational; unaffected by FSM):
  - FWD_A=10 if EXMEM_RegWrite and EXMEM_WRITE_REG!=0 and EXMEM_WRITE_REG==IDEX_Rs.
  - Otherwise FWD_A=01 if the same test holds with MEMWB signals.
  - Otherwise FWD_A=00. FWD_B is identical using IDEX_Rt.
  - The EX/MEM match wins over the MEM/WB match.
- FSM states: RUN=0, LU_STALL=1, MEM_WAIT=2, REDIRECT=3.
- Event priority each cycle: MEM_READY=0 > PC_SRC > IDEX_Jump > load-use.
- MEM_WAIT/freeze, when MEM_READY=0:
  - PC_WRITE=0, IFID_WRITE=0; all flush/bubble=0.
  - Next state MEM_WAIT. STALL_CNT+1 per cycle.
  - The freeze holds every stage; the datapath gates ID/EX, EX/MEM and MEM/WB with PC_WRITE.
- Branch (PC_SRC=1, MEM_READY=1):
  - IFID_FLUSH=1, IDEX_BUBBLE=1, EXMEM_FLUSH=1. PC_WRITE=1.
  - Next state REDIRECT. FLUSH_CNT+1.
- Jump (IDEX_Jump=1, no branch):
  - IFID_FLUSH=1, IDEX_BUBBLE=1. PC_WRITE=1.
  - Next state REDIRECT. FLUSH_CNT+1.
- Load-use, triggered when IDEX_MemRead=1, IDEX_Rt!=0, and (IDEX_Rt==IFID_Rs or (IFID_UsesRt and IDEX_Rt==IFID_Rt)):
  - Only while STATE is RUN or MEM_WAIT.
  - PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1.
  - Next state LU_STALL. STALL_CNT+1.
- LU_STALL: the load-use check is suppressed, so a stall lasts exactly 1 cycle. Branch, jump and freeze are still honoured.
- REDIRECT: load-use check suppressed for 1 cycle, because the IF/ID contents are a flushed NOP.
- Exit from LU_STALL and REDIRECT: the next cycle with no event returns to RUN.
- Exit from MEM_WAIT: on MEM_READY=1, the load-use check runs normally in that cycle.
- Counters: saturate at all-ones; they do not wrap.
- Reset mid-stall or mid-wait: immediate return to RUN. Outputs take their RUN values.

Decomposition:
- Shared package mips_pkg:
  - FSM state encodings.
  - Forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
  - Register $zero index.
- Sub-module fwd_unit: the combinational forwarding compare, instantiated once, producing FWD_A and FWD_B.

Test Plan:
- lw $2,0($1) then add $3,$2,$4 -> one cycle with PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1, STATE=1; next cycle FWD_A=01; STALL_CNT=1.
- add $2,... ; sub $5,$2,$2 -> FWD_A=10 and FWD_B=10, no stall. With add $0 as the producer instead -> FWD=00.
- Taken beq (PC_SRC=1) with IDEX_Jump=1 the same cycle -> IFID_FLUSH=1, IDEX_BUBBLE=1, EXMEM_FLUSH=1, STATE=3; FLUSH_CNT increments by exactly 1.
- MEM_READY low for 3 cycles during a load-use hazard -> freeze 3 cycles (STATE=2, no bubble), then the load-use stall; STALL_CNT=4.
- Force STALL_CNT to 16'hFFFF, then stall -> it stays 16'hFFFF.
- Assert RST_N=0 mid-LU_STALL between clock edges -> STATE=0 and counters=0 immediately, without waiting for a CLK edge.
